// File: rtl/pe_row_sequencer.sv
// Row-convolution sequencer for one glb_PE: streams K weight beats, then a sliding
// K-tap ifmap window per output, drives the PE selects and hands off each psum.
module pe_row_sequencer #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned NUM_COL    = 4,
   parameter int unsigned MAX_K      = 8,
   parameter int unsigned MAX_OW     = 32,
   parameter int unsigned AW         = 8,
   parameter int unsigned PE_LAT     = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [$clog2(MAX_K+1)-1:0]    cfg_k,
   input  logic [$clog2(MAX_OW+1)-1:0]   cfg_ow,
   input  logic [$clog2(NUM_COL)-1:0]    cfg_col,
   output logic                          busy,
   output logic                          done,
   output logic                          bus_valid,
   input  logic                          bus_ready,
   output logic                          bus_kind,
   output logic [AW-1:0]                 bus_addr,
   output logic [$clog2(NUM_COL)-1:0]    bus_tag,
   output logic                          mult_seln,
   output logic                          acc_seln,
   output logic                          psum_valid,
   input  logic                          psum_ready
);

   localparam int unsigned KW  = $clog2(MAX_K + 1);
   localparam int unsigned OWW = $clog2(MAX_OW + 1);
   localparam int unsigned TW  = $clog2(NUM_COL);
   localparam int unsigned WW  = $clog2(PE_LAT + 1);

   // Parameter sanity: ifmap addresses must fit in AW without wrapping.
   if (DATA_WIDTH == 0 || PE_LAT == 0 ||
       (64'(1) << AW) <= 64'(MAX_OW + MAX_K - 2)) begin : g_bad_cfg
      $error("pe_row_sequencer: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_MAC, S_WAIT_PE, S_DRAIN, S_FINISH
   } state_e;

   state_e          state_q, state_d;
   logic [KW-1:0]   k_q, k_d, kcfg_q, kcfg_d;
   logic [OWW-1:0]  o_q, o_d, owcfg_q, owcfg_d;
   logic [WW-1:0]   w_q, w_d;
   logic [TW-1:0]   tag_q, tag_d;
   logic            busy_q, busy_d, done_q, done_d, valid_q, valid_d, kind_q, kind_d;
   logic            mult_q, mult_d, acc_q, acc_d, pv_q, pv_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [KW-1:0]   k_sat;
   logic [OWW-1:0]  ow_sat;
   logic            last_k;

   assign k_sat  = (32'(cfg_k)  > MAX_K)  ? KW'(MAX_K)   : cfg_k;
   assign ow_sat = (32'(cfg_ow) > MAX_OW) ? OWW'(MAX_OW) : cfg_ow;
   assign last_k = (k_q == KW'(kcfg_q - KW'(1)));

   // Next state and counters; outputs are decoded from the next state and registered.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      o_d     = o_q;
      w_d     = w_q;
      kcfg_d  = kcfg_q;
      owcfg_d = owcfg_q;
      tag_d   = tag_q;
      if (abort) begin
         state_d = S_IDLE;
         k_d     = '0;
         o_d     = '0;
         w_d     = '0;
         tag_d   = '0;
      end else begin
         unique case (state_q)
            S_IDLE: if (start) begin
               kcfg_d  = k_sat;
               owcfg_d = ow_sat;
               tag_d   = cfg_col;
               k_d     = '0;
               o_d     = '0;
               w_d     = '0;
               state_d = (k_sat == '0 || ow_sat == '0) ? S_FINISH : S_LOAD_W;
            end
            S_LOAD_W: if (bus_ready) begin
               if (last_k) begin
                  k_d     = '0;
                  o_d     = '0;
                  state_d = S_MAC;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
            S_MAC: if (bus_ready) begin
               if (last_k) begin
                  w_d     = '0;
                  state_d = S_WAIT_PE;
               end else begin
                  k_d = k_q + KW'(1);
               end
            end
            S_WAIT_PE: begin
               if (w_q == WW'(PE_LAT - 1)) state_d = S_DRAIN;
               else                        w_d     = w_q + WW'(1);
            end
            S_DRAIN: if (psum_ready) begin
               if (o_q == OWW'(owcfg_q - OWW'(1))) begin
                  state_d = S_FINISH;
               end else begin
                  o_d     = o_q + OWW'(1);
                  k_d     = '0;
                  state_d = S_MAC;
               end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end

      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_FINISH);
      valid_d = (state_d == S_LOAD_W) || (state_d == S_MAC);
      kind_d  = (state_d == S_MAC);
      mult_d  = (state_d != S_MAC);
      acc_d   = !((state_d == S_MAC) && (k_d != '0));
      pv_d    = (state_d == S_DRAIN);
      unique case (state_d)
         S_LOAD_W: addr_d = AW'(k_d);
         S_MAC:    addr_d = AW'(o_d) + AW'(k_d);
         default:  addr_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         o_q     <= '0;
         w_q     <= '0;
         kcfg_q  <= '0;
         owcfg_q <= '0;
         tag_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         valid_q <= 1'b0;
         kind_q  <= 1'b0;
         addr_q  <= '0;
         mult_q  <= 1'b1;
         acc_q   <= 1'b1;
         pv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         o_q     <= o_d;
         w_q     <= w_d;
         kcfg_q  <= kcfg_d;
         owcfg_q <= owcfg_d;
         tag_q   <= tag_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         valid_q <= valid_d;
         kind_q  <= kind_d;
         addr_q  <= addr_d;
         mult_q  <= mult_d;
         acc_q   <= acc_d;
         pv_q    <= pv_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign bus_valid  = valid_q;
   assign bus_kind   = kind_q;
   assign bus_addr   = addr_q;
   assign bus_tag    = tag_q;
   assign mult_seln  = mult_q;
   assign acc_seln   = acc_q;
   assign psum_valid = pv_q;

endmodule

// File: tb/tb_pe_row_sequencer.sv
// Self-checking bench for pe_row_sequencer: directed and randomized rows checked
// against a beat-sequence / latency model derived from the row-convolution rules.
module tb_pe_row_sequencer;

   localparam int MAX_K  = 8;
   localparam int MAX_OW = 32;
   localparam int PE_LAT = 2;

   logic       clk = 1'b0;
   logic       rst, start, abort;
   logic [3:0] cfg_k;
   logic [5:0] cfg_ow;
   logic [1:0] cfg_col;
   logic       busy, done, bus_valid, bus_ready, bus_kind, mult_seln, acc_seln;
   logic       psum_valid, psum_ready;
   logic [7:0] bus_addr;
   logic [1:0] bus_tag;

   pe_row_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_k(cfg_k), .cfg_ow(cfg_ow), .cfg_col(cfg_col),
      .busy(busy), .done(done),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_kind(bus_kind),
      .bus_addr(bus_addr), .bus_tag(bus_tag),
      .mult_seln(mult_seln), .acc_seln(acc_seln),
      .psum_valid(psum_valid), .psum_ready(psum_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int passed = 0;
   int fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Ready generation: 0 = always ready, 1 = random, 2 = 3-cycle bus stall on ifmap addr 2,
   // 3 = 5-cycle psum stall on first psum.
   int mode = 0;
   int trig = 0;
   int hold = 0;
   initial begin
      bus_ready  = 1'b1;
      psum_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            1: begin
               trig = 0;
               bus_ready  = ($urandom_range(0, 3) != 0);
               psum_ready = ($urandom_range(0, 3) != 0);
            end
            2: begin
               psum_ready = 1'b1;
               if (trig == 0 && bus_valid && bus_kind && bus_addr == 8'd2) begin
                  trig = 1;
                  hold = 3;
               end
               bus_ready = (hold == 0);
               if (hold > 0) hold--;
            end
            3: begin
               bus_ready = 1'b1;
               if (trig == 0 && psum_valid) begin
                  trig = 1;
                  hold = 5;
               end
               psum_ready = (hold == 0);
               if (hold > 0) hold--;
            end
            default: begin
               trig = 0;
               hold = 0;
               bus_ready  = 1'b1;
               psum_ready = 1'b1;
            end
         endcase
      end
   end

   // Observer: logs accepted beats, psum transfers, done pulses and protocol violations.
   int   obs_kind[$];
   int   obs_addr[$];
   int   obs_acc[$];
   int   obs_tag[$];
   int   psum_cnt = 0, done_cnt = 0, done_cyc = 0;
   int   stab_viol = 0, sel_viol = 0, overlap_viol = 0;
   logic prev_bstall = 1'b0, prev_pstall = 1'b0;
   logic p_kind, p_acc, p_mult;
   logic [7:0] p_addr;
   logic [1:0] p_tag;
   always @(negedge clk) begin
      if (!(rst || abort)) begin
         if (bus_valid && bus_ready) begin
            obs_kind.push_back(int'(bus_kind));
            obs_addr.push_back(int'(bus_addr));
            obs_acc.push_back(int'(acc_seln));
            obs_tag.push_back(int'(bus_tag));
         end
         if (psum_valid && psum_ready) psum_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (prev_bstall && !(bus_valid && bus_kind == p_kind && bus_addr == p_addr &&
             acc_seln == p_acc && bus_tag == p_tag && mult_seln == p_mult)) stab_viol++;
         if (prev_pstall && !psum_valid) stab_viol++;
         if (mult_seln != !(bus_valid && bus_kind)) sel_viol++;
         if (!bus_valid && !acc_seln) sel_viol++;
         if (bus_valid && psum_valid) overlap_viol++;
      end
      prev_bstall = !(rst || abort) && bus_valid && !bus_ready;
      prev_pstall = !(rst || abort) && psum_valid && !psum_ready;
      p_kind = bus_kind;
      p_addr = bus_addr;
      p_acc  = acc_seln;
      p_tag  = bus_tag;
      p_mult = mult_seln;
   end

   function automatic logic [31:0] out_vec();
      return 32'({busy, done, bus_valid, bus_kind, bus_addr, bus_tag, mult_seln, acc_seln,
                  psum_valid});
   endfunction
   localparam logic [31:0] RESET_VEC = 32'h6;

   task automatic pulse_start(input int k_in, input int ow_in, input int col);
      @(posedge clk);
      #1;
      start   = 1'b1;
      cfg_k   = 4'(k_in);
      cfg_ow  = 6'(ow_in);
      cfg_col = 2'(col);
   endtask

   // Runs one row and compares it with the model: beat list, psum count, done, latency.
   task automatic run_row(input string name, input int k_in, input int ow_in, input int col,
                          input int md, input int extra, input int restart_at);
      int k, ow, bq, bp, bd, bv, sc, n, nb, exp_n, bad, ek, ea, eacc, j, lat;
      bit got;
      k  = (k_in > MAX_K) ? MAX_K : k_in;
      ow = (ow_in > MAX_OW) ? MAX_OW : ow_in;
      mode = md;
      bq = obs_kind.size();
      bp = psum_cnt;
      bd = done_cnt;
      bv = stab_viol + sel_viol + overlap_viol;
      pulse_start(k_in, ow_in, col);
      sc = cyc;
      @(posedge clk);
      #1;
      start   = 1'b0;
      cfg_k   = 4'($urandom);
      cfg_ow  = 6'($urandom);
      cfg_col = 2'($urandom);
      got = 0;
      n = 0;
      while (!got && n < 4000) begin
         @(negedge clk);
         n++;
         if (done_cnt != bd) got = 1;
         if (restart_at > 0 && n == restart_at) begin
            pulse_start(5, 7, (col + 1) % 4);
            @(posedge clk);
            #1;
            start = 1'b0;
         end
      end
      mode = 0;
      repeat (3) @(negedge clk);
      check({name, "_done_seen"}, 32'(got), 32'd1);
      check({name, "_done_count"}, 32'(done_cnt - bd), 32'd1);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
      if (md != 1) begin
         lat = (k == 0 || ow == 0) ? 2 : 1 + k + ow * (k + PE_LAT + 1) + 1 + extra;
         check({name, "_latency"}, 32'(done_cyc - sc + 1), 32'(lat));
      end
      exp_n = (k == 0 || ow == 0) ? 0 : k + ow * k;
      nb = obs_kind.size() - bq;
      check({name, "_beat_count"}, 32'(nb), 32'(exp_n));
      bad = 0;
      for (int i = 0; i < exp_n && i < nb; i++) begin
         if (i < k) begin
            ek = 0; ea = i; eacc = 0;
         end else begin
            j = i - k;
            ek = 1; ea = j / k + j % k; eacc = (j % k == 0) ? 1 : 0;
         end
         if (obs_kind[bq+i] != ek || obs_addr[bq+i] != ea || obs_tag[bq+i] != col ||
             (ek == 1 && obs_acc[bq+i] != eacc)) bad++;
      end
      check({name, "_beat_seq"}, 32'(bad), 32'd0);
      check({name, "_psums"}, 32'(psum_cnt - bp), 32'((k == 0 || ow == 0) ? 0 : ow));
      check({name, "_protocol"}, 32'(stab_viol + sel_viol + overlap_viol - bv), 32'd0);
   endtask

   // Kills a K=3/OW=2 row in its second MAC window with abort or rst.
   task automatic kill_row(input string name, input bit use_rst);
      int bp, bd;
      bit found;
      mode = 0;
      bp = psum_cnt;
      bd = done_cnt;
      pulse_start(3, 2, 2);
      @(posedge clk);
      #1;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge clk);
         if (psum_cnt - bp >= 1 && bus_valid) found = 1;
      end
      check({name, "_reached_mac2"}, 32'(found), 32'd1);
      @(posedge clk);
      #1;
      if (use_rst) rst = 1'b1;
      else         abort = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
      abort = 1'b0;
      @(negedge clk);
      check({name, "_outputs_reset"}, out_vec(), RESET_VEC);
      repeat (20) @(negedge clk);
      check({name, "_no_done"}, 32'(done_cnt - bd), 32'd0);
      check({name, "_stay_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      rst = 1'b1; abort = 1'b0; start = 1'b0;
      cfg_k = '0; cfg_ow = '0; cfg_col = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs", out_vec(), RESET_VEC);

      run_row("basic", 3, 2, 2, 0, 0, 0);
      run_row("bus_stall", 3, 2, 2, 2, 3, 0);
      run_row("psum_stall", 3, 2, 2, 3, 5, 0);
      run_row("zero_k", 0, 4, 1, 0, 0, 0);
      run_row("zero_ow", 5, 0, 3, 0, 0, 0);
      run_row("saturate", 15, 63, 3, 0, 0, 0);
      run_row("k1", 1, 5, 0, 0, 0, 0);
      run_row("start_busy", 3, 2, 2, 0, 0, 5);

      kill_row("abort", 1'b0);
      kill_row("rst", 1'b1);
      run_row("after_kill", 3, 2, 2, 0, 0, 0);

      // start and abort together in IDLE must not launch a row
      @(posedge clk);
      #1;
      start = 1'b1; abort = 1'b1; cfg_k = 4'd3; cfg_ow = 6'd2;
      @(posedge clk);
      #1;
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      check("start_abort_idle", out_vec(), RESET_VEC);

      for (int r = 0; r < 8; r++) begin
         run_row($sformatf("rand%0d", r), int'($urandom_range(0, 10)),
                 int'($urandom_range(1, 35)), int'($urandom_range(0, 3)), 1, 0, 0);
      end
      run_row("final_clean", 4, 6, 1, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pe_row_sequencer.md
Name: pe_row_sequencer

Overview:
- Controller that drives one glb_PE through a 1-D row convolution.
- Issues weight and ifmap beats on a tagged multicast request channel: K weight beats, then a sliding window of K ifmap beats per output.
- Generates the PE's mult_seln/acc_seln controls, waits out PE latency, and hands each finished psum downstream with a valid/ready handshake.
- Sits between the global-buffer control and the glb_PE column, replacing the temporarily IOed select pins.

Parameters:
- DATA_WIDTH, 16, PE datapath width (pass-through for integration only).
- NUM_COL, 4, number of PE columns; sets tag width.
- MAX_K, 8, maximum filter taps.
- MAX_OW, 32, maximum outputs per row.
- AW, 8, buffer address width; must satisfy 2^AW > MAX_OW+MAX_K-2.
- PE_LAT, 2, cycles from last accepted tap beat to psum ready in PE (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin row; sampled only in IDLE
- abort  in  1  synchronous abort, return to IDLE
- cfg_k  in  $clog2(MAX_K+1)  filter taps K
- cfg_ow  in  $clog2(MAX_OW+1)  outputs OW
- cfg_col  in  $clog2(NUM_COL)  destination column tag
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on row completion
- bus_valid  out  1  request beat valid
- bus_ready  in  1  multicaster accepts beat
- bus_kind  out  1  0=weight, 1=ifmap
- bus_addr  out  AW  buffer address of beat
- bus_tag  out  $clog2(NUM_COL)  column tag (latched cfg_col)
- mult_seln  out  1  0=multiplier active, 1=multiplier bypassed/idle
- acc_seln  out  1  0=accumulate onto psum, 1=load fresh product (first tap)
- psum_valid  out  1  psum available at PE output
- psum_ready  in  1  downstream consumes psum

Behaviour:
- Reset (rst=1 at edge): state IDLE; busy=0, done=0, bus_valid=0, bus_kind=0, bus_addr=0, bus_tag=0, mult_seln=1, acc_seln=1, psum_valid=0; counters cleared. Reset or abort mid-row takes effect at the next edge; no done pulse, in-flight beat dropped.
- Config latch: in IDLE with start=1, latch cfg_k (saturate to MAX_K), cfg_ow (saturate to MAX_OW) and cfg_col. start while busy is ignored.
- Zero config: K=0 or OW=0 goes IDLE->FINISH; done pulses the next cycle; no bus beats, no psum.
- States: IDLE, LOAD_W, MAC, WAIT_PE, DRAIN, FINISH.
- LOAD_W: bus_valid=1, bus_kind=0, bus_addr=k for k=0..K-1; mult_seln=1.
  - k advances only on bus_valid&&bus_ready.
  - After the beat with k=K-1 is accepted, go to MAC with o=0, k=0.
- MAC: bus_valid=1, bus_kind=1, bus_addr=o+k; mult_seln=0; acc_seln=1 when k=0, else 0.
  - All bus_* and select outputs are registered and held stable while bus_ready=0.
  - On acceptance of k=K-1, go to WAIT_PE; bus_valid=0, mult_seln=1, acc_seln=1 from the next cycle.
- WAIT_PE: count PE_LAT cycles, then DRAIN.
- DRAIN: psum_valid=1 held until psum_ready=1 (transfer cycle).
  - After transfer: if o=OW-1, go to FINISH; else o++, k=0, and go to MAC.
  - psum_valid deasserts the cycle after transfer.
- FINISH: done=1 for exactly one cycle, then IDLE.
- Address arithmetic: bus_addr=o+k computed in AW bits, no wrap within legal config. Max ifmap address is OW+K-2.
- Beat counts: total bus beats = K + OW*K; ifmap beats with acc_seln=1 = OW.
- Simultaneous events:
  - rst has priority over abort, and abort over everything else.
  - abort and a psum_ready transfer in the same cycle: the transfer is considered lost.
  - start and abort together in IDLE: stay IDLE.
- With bus_ready=psum_ready=1 constantly, row latency from the start cycle to done = 1 + K + OW*(K+PE_LAT+1) + 1 cycles.

Test Plan:
- K=3, OW=2, cfg_col=2, ready tied high:
  - weight addrs 0,1,2;
  - ifmap addrs 0,1,2,1,2,3 with acc_seln 1,0,0,1,0,0;
  - bus_tag=2 throughout; two psum_valid transfers; done one pulse.
  - Cycle count = 1+3+2*(3+2+1)+1 = 17.
- Backpressure: same config with bus_ready low for 3 cycles during ifmap beat addr 2 -> bus_addr, bus_kind, acc_seln held stable; sequence unchanged; done delayed by 3.
- psum stall: psum_ready low for 5 cycles on the first psum -> psum_valid held high, bus_valid=0, no MAC beats until transfer; second output then proceeds.
- Zero/saturated config: cfg_k=0, OW=4 -> done 2 cycles after start with no bus_valid. cfg_k=15 with MAX_K=8 -> exactly 8 weight beats.
- Abort/reset mid-row: abort during the 2nd MAC window -> IDLE next cycle, all outputs at reset values, no done. The same case with rst matches. A new start then runs a clean full row.
- start pulsed while busy -> ignored; config unchanged; single done at the end of the original row.
